// File: rtl/blood_ph_sampler.sv
// blood_ph_sampler: pH probe front end.
// Synchronizes the probe line and decodes 7-bit UART-style frames
// (start, 4 data bits LSB first, even parity, stop). Good samples are
// averaged over 2^AVG_LOG2 frames before being presented on bloodPH.
// Optional feature macro: BLOOD_PH_STALE_EN adds the sensorStale output
// and the staleness timer sized by TIMEOUT_CYCLES.
//
// Output strobes: phValid and frameError are single-cycle pulses with no
// ready/back-pressure. phValid marks the cycle in which bloodPH carries a
// freshly updated value. frameError marks a rejected frame. The two are
// never high together.
module blood_ph_sampler #(
    parameter int BIT_CYCLES = 16,
    parameter int AVG_LOG2   = 2
`ifdef BLOOD_PH_STALE_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phSerial,
    output logic [3:0] bloodPH,
    output logic       phValid,
    output logic       frameError
`ifdef BLOOD_PH_STALE_EN
    ,
    output logic       sensorStale
`endif
);

    localparam int TW   = $clog2(BIT_CYCLES);
    localparam int AW   = 4 + AVG_LOG2;
    localparam int CNTW = AVG_LOG2 + 1;
    localparam logic [TW-1:0]   FULL_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0]   HALF_LAST = TW'(BIT_CYCLES / 2 - 1);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } stateT;

    stateT           state;
    stateT           nextState;
    logic [1:0]      syncQ;
    logic            sync;
    logic [TW-1:0]   bitTimer;
    logic [1:0]      bitIdx;
    logic [3:0]      shiftReg;
    logic            parityBit;
    logic            bitTick;
    logic            frameDone;
    logic            frameGood;
    logic            frameBad;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   sum;
    logic [CNTW-1:0] sampleCnt;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) syncQ <= 2'b11;
        else     syncQ <= {syncQ[0], phSerial};
    end

    assign sync = syncQ[1];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // FSM next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!sync) nextState = START;
            START:   if (bitTick) nextState = sync ? IDLE : DATA;
            DATA:    if (bitTick && bitIdx == 2'd3) nextState = PARITY;
            PARITY:  if (bitTick) nextState = STOP;
            STOP:    if (bitTick) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // FSM outputs: bit sample strobe and end-of-frame verdict.
    always_comb begin
        bitTick   = 1'b0;
        frameDone = 1'b0;
        frameGood = 1'b0;
        frameBad  = 1'b0;
        case (state)
            START:               bitTick = (bitTimer == HALF_LAST);
            DATA, PARITY, STOP:  bitTick = (bitTimer == FULL_LAST);
            default:             bitTick = 1'b0;
        endcase
        frameDone = (state == STOP) && bitTick;
        frameGood = frameDone && sync && ((^shiftReg) == parityBit);
        frameBad  = frameDone && !frameGood;
    end

    // Bit timing, data shift register and parity capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitTimer  <= '0;
            bitIdx    <= 2'd0;
            shiftReg  <= 4'd0;
            parityBit <= 1'b0;
        end else begin
            if (state == IDLE || bitTick) bitTimer <= '0;
            else                          bitTimer <= bitTimer + TW'(1);

            if (state != DATA) bitIdx <= 2'd0;
            else if (bitTick)  bitIdx <= bitIdx + 2'd1;

            if (state == DATA && bitTick)   shiftReg  <= {sync, shiftReg[3:1]};
            if (state == PARITY && bitTick) parityBit <= sync;
        end
    end

    assign sum = acc + AW'(shiftReg);

    // Averaging of good samples and output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            sampleCnt  <= '0;
            bloodPH    <= 4'd0;
            phValid    <= 1'b0;
            frameError <= 1'b0;
        end else begin
            phValid    <= 1'b0;
            frameError <= frameBad;
            if (frameGood) begin
                if (sampleCnt == CNT_LAST) begin
                    bloodPH   <= sum[AW-1:AVG_LOG2];
                    phValid   <= 1'b1;
                    acc       <= '0;
                    sampleCnt <= '0;
                end else begin
                    acc       <= sum;
                    sampleCnt <= sampleCnt + CNTW'(1);
                end
            end
        end
    end

`ifdef BLOOD_PH_STALE_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STALE_LIMIT = SW'(TIMEOUT_CYCLES);

    logic [SW-1:0] staleCnt;

    // Staleness timer: saturates at the limit, restarts on each new value.
    always_ff @(posedge clk) begin
        if (rst)                          staleCnt <= '0;
        else if (phValid)                 staleCnt <= '0;
        else if (staleCnt != STALE_LIMIT) staleCnt <= staleCnt + SW'(1);
    end

    assign sensorStale = (staleCnt == STALE_LIMIT);
`endif

endmodule

// File: tb/tb_blood_ph_sampler.sv
// Bench for blood_ph_sampler: one averaging instance (AVG_LOG2=2) and one
// pass-through instance (AVG_LOG2=0) share the probe line. Stimulus issues
// frames and pushes expected outputs; monitors pop and compare on pulses.
module tb_blood_ph_sampler;

    localparam int BC  = 8;
    localparam int LAT = 2 + BC / 2 + 6 * BC + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       phSerial = 1'b1;
    logic [3:0] phAvg;
    logic       validAvg;
    logic       errAvg;
    logic [3:0] ph0;
    logic       valid0;
    logic       err0;
`ifdef BLOOD_PH_STALE_EN
    logic       staleAvg;
    logic       stale0;
    logic       staleChkPending = 1'b0;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int pulseAvg   = 0;
    int pulse0     = 0;

    // Entries are {isError, data}.
    logic [4:0] expAvgQ[$];
    logic [4:0] exp0Q[$];
    int         fallQ[$];

    blood_ph_sampler #(
        .BIT_CYCLES(BC),
`ifdef BLOOD_PH_STALE_EN
        .TIMEOUT_CYCLES(100),
`endif
        .AVG_LOG2(2)
    ) dutAvg (
        .clk(clk),
        .rst(rst),
        .phSerial(phSerial),
`ifdef BLOOD_PH_STALE_EN
        .sensorStale(staleAvg),
`endif
        .bloodPH(phAvg),
        .phValid(validAvg),
        .frameError(errAvg)
    );

    blood_ph_sampler #(
        .BIT_CYCLES(BC),
`ifdef BLOOD_PH_STALE_EN
        .TIMEOUT_CYCLES(100),
`endif
        .AVG_LOG2(0)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .phSerial(phSerial),
`ifdef BLOOD_PH_STALE_EN
        .sensorStale(stale0),
`endif
        .bloodPH(ph0),
        .phValid(valid0),
        .frameError(err0)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame starting now; the line ends high right after the stop bit.
    task automatic sendFrame(input logic [3:0] d, input logic parFlip, input logic stopBit,
                             input logic avgOut, input logic [3:0] avgVal);
        logic [6:0] bits;
        logic       good;
        good = !parFlip && stopBit;
        bits = {stopBit, (^d) ^ parFlip, d, 1'b0};
        exp0Q.push_back(good ? {1'b0, d} : 5'b10000);
        fallQ.push_back(cyc);
        if (!good)       expAvgQ.push_back(5'b10000);
        else if (avgOut) expAvgQ.push_back({1'b0, avgVal});
        for (int i = 0; i < 7; i++) begin
            phSerial = bits[i];
            repeat (BC) @(posedge clk);
            #1;
        end
        phSerial = 1'b1;
    endtask

    // Monitor for the averaging instance.
    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst) begin
`ifdef BLOOD_PH_STALE_EN
            if (staleChkPending) begin
                check("staleDropAfterValid", int'(staleAvg), 0);
                staleChkPending = 1'b0;
            end
`endif
            if (validAvg && errAvg) check("avgValidErrExclusive", 1, 0);
            if (validAvg || errAvg) begin
                pulseAvg++;
                if (expAvgQ.size() == 0) begin
                    check("avgUnexpectedPulse", int'({errAvg, phAvg}), -1);
                end else begin
                    e = expAvgQ.pop_front();
                    check("avgIsError", int'(errAvg), int'(e[4]));
                    if (!e[4]) check("avgBloodPH", int'(phAvg), int'(e[3:0]));
                end
`ifdef BLOOD_PH_STALE_EN
                if (validAvg) staleChkPending = 1'b1;
`endif
            end
        end
    end

    // Monitor for the pass-through instance, including latency.
    always @(negedge clk) begin
        logic [4:0] e;
        int         f;
        if (!rst) begin
            if (valid0 && err0) check("p0ValidErrExclusive", 1, 0);
            if (valid0 || err0) begin
                pulse0++;
                if (exp0Q.size() == 0) begin
                    check("p0UnexpectedPulse", int'({err0, ph0}), -1);
                end else begin
                    e = exp0Q.pop_front();
                    f = fallQ.pop_front();
                    check("p0IsError", int'(err0), int'(e[4]));
                    if (!e[4]) check("p0BloodPH", int'(ph0), int'(e[3:0]));
                    check("p0Latency", cyc - f, LAT);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int before0;
        int beforeAvg;

        // Reset values.
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rstBloodPHAvg", int'(phAvg), 0);
        check("rstBloodPH0", int'(ph0), 0);
        check("rstValid", int'(validAvg | valid0), 0);
        check("rstError", int'(errAvg | err0), 0);
`ifdef BLOOD_PH_STALE_EN
        check("rstStale", int'(staleAvg), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Long idle: staleness reached after 100 cycles.
        idle(120);
`ifdef BLOOD_PH_STALE_EN
        check("staleAfterIdle", int'(staleAvg), 1);
`endif

        // Pass-through value and latency, then a second sample.
        sendFrame(4'b1010, 1'b0, 1'b1, 1'b0, 4'd0);
        sendFrame(4'd15, 1'b0, 1'b1, 1'b0, 4'd0);
        check("avgHeldBeforeReset", int'(phAvg), 0);

        // Reset mid-frame: drop into DATA, then reset.
        phSerial = 1'b0;
        idle(20);
        rst = 1'b1;
        phSerial = 1'b1;
        idle(3);
        @(negedge clk);
        check("midRstBloodPH0", int'(ph0), 0);
        check("midRstPulses", int'(validAvg | errAvg | valid0 | err0), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        // Accumulator cleared by reset: four 9s average to 9.
        sendFrame(4'd9, 1'b0, 1'b1, 1'b0, 4'd0);
        sendFrame(4'd9, 1'b0, 1'b1, 1'b0, 4'd0);
        sendFrame(4'd9, 1'b0, 1'b1, 1'b0, 4'd0);
        sendFrame(4'd9, 1'b0, 1'b1, 1'b1, 4'd9);

        // Averaging 7,8,8,9 -> 8; bloodPH holds 9 until then.
        sendFrame(4'd7, 1'b0, 1'b1, 1'b0, 4'd0);
        check("avgHeld1", int'(phAvg), 9);
        sendFrame(4'd8, 1'b0, 1'b1, 1'b0, 4'd0);
        check("avgHeld2", int'(phAvg), 9);
        sendFrame(4'd8, 1'b0, 1'b1, 1'b0, 4'd0);
        check("avgHeld3", int'(phAvg), 9);
        sendFrame(4'd9, 1'b0, 1'b1, 1'b1, 4'd8);

        // Errors interleaved with good 15s; bad frames must not accumulate.
        sendFrame(4'd15, 1'b0, 1'b1, 1'b0, 4'd0);
        sendFrame(4'd5, 1'b1, 1'b1, 1'b0, 4'd0);
        sendFrame(4'd15, 1'b0, 1'b1, 1'b0, 4'd0);
        sendFrame(4'd3, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(30);
        sendFrame(4'd15, 1'b0, 1'b1, 1'b0, 4'd0);
        sendFrame(4'd15, 1'b0, 1'b1, 1'b1, 4'd15);
        idle(10);

        // Glitch: two cycles low, then back high.
        before0   = pulse0;
        beforeAvg = pulseAvg;
        phSerial = 1'b0;
        idle(2);
        phSerial = 1'b1;
        idle(30);
        check("glitchNoPulse0", pulse0, before0);
        check("glitchNoPulseAvg", pulseAvg, beforeAvg);
        sendFrame(4'd6, 1'b0, 1'b1, 1'b0, 4'd0);
        check("avgHeldAfterGlitch", int'(phAvg), 15);

        // Drain and confirm every expectation was consumed.
        idle(40);
        check("avgQueueEmpty", expAvgQ.size(), 0);
        check("p0QueueEmpty", exp0Q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
